// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mul_pkg
//  Brief    : Shared types and constants for the sequential shift-and-add
//             multiplier (state encoding, operand/product/count widths).
//  Revision : 1.0 - initial release
// ============================================================================
package mul_pkg;

    localparam int MUL_WIDTH   = 32;
    localparam int PROD_WIDTH  = 2 * MUL_WIDTH;
    localparam int COUNT_WIDTH = $clog2(MUL_WIDTH) + 1;

    // Explicit 2-bit encoding so the state register width is fixed
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : mul_pkg
`default_nettype wire

// File: rtl/left_shifter_1.sv
`default_nettype none
// ============================================================================
//  Module   : left_shifter_1
//  Brief    : Single-position logical left shifter; the vacated LSB is
//             always filled with 0.
//  Revision : 1.0 - initial release
// ============================================================================
module left_shifter_1 #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    // Drop the MSB, insert a constant 0 at the LSB
    assign o_data = {i_data[WIDTH-2:0], 1'b0};

endmodule : left_shifter_1
`default_nettype wire

// File: rtl/seq_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : seq_shift_add_multiplier
//  Brief    : Unsigned sequential shift-and-add multiplier. One partial
//             product per cycle, exactly WIDTH iterations, start/done
//             handshake, product held until the next accepted start.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_shift_add_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int                    c_PROD_WIDTH  = 2 * WIDTH;
    localparam int                    c_COUNT_WIDTH = $clog2(WIDTH) + 1;
    localparam logic [c_COUNT_WIDTH-1:0] c_LAST_ITER = c_COUNT_WIDTH'(WIDTH - 1);

    state_t                     r_state;
    logic [c_PROD_WIDTH-1:0]    r_mcand;
    logic [WIDTH-1:0]           r_mplier;
    logic [c_PROD_WIDTH-1:0]    r_acc;
    logic [c_COUNT_WIDTH-1:0]   r_count;
    logic                       r_busy;
    logic                       r_done;
    logic [c_PROD_WIDTH-1:0]    w_mcandShifted;

    // Shift path for the multiplicand; its zero LSB keeps the shift logical
    left_shifter_1 #(
        .WIDTH (c_PROD_WIDTH)
    ) u_shifter (
        .i_data (r_mcand),
        .o_data (w_mcandShifted)
    );

    // Control FSM and datapath; busy/done are registered alongside the state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                // DONE accepts a new start exactly like IDLE, which gives
                // back-to-back operation without an idle bubble
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_mcand  <= {{(c_PROD_WIDTH-WIDTH){1'b0}}, multiplicand};
                        r_mplier <= multiplier;
                        r_acc    <= '0;
                        r_count  <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= BUSY;
                    end else begin
                        r_state  <= IDLE;
                    end
                end
                // One partial product per cycle; start is ignored here
                BUSY: begin
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand  <= w_mcandShifted;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + 1'b1;
                    if (r_count == c_LAST_ITER) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_acc;

endmodule : seq_shift_add_multiplier
`default_nettype wire

// File: tb/tb_seq_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_shift_add_multiplier
//  Brief    : Directed self-checking bench for seq_shift_add_multiplier.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_shift_add_multiplier;

    localparam int c_W       = 32;
    localparam int c_LATENCY = c_W + 1;   // done cycle counted from accept edge
    localparam int c_MAXCYC  = 40;

    logic             clock;
    logic             reset;
    logic             start;
    logic [c_W-1:0]   multiplicand;
    logic [c_W-1:0]   multiplier;
    logic             busy;
    logic             done;
    logic [2*c_W-1:0] product;

    int errors = 0;
    int checks = 0;

    seq_shift_add_multiplier #(
        .WIDTH (c_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Issue one operation and observe it cycle by cycle (cycle 1 is the one
    // after the accepting edge). Optionally re-asserts start with different
    // operands during cycles holdFrom..holdTo; optionally returns while still
    // in the done cycle so the caller can chain another start.
    task automatic run_mult(input logic [c_W-1:0] a, input logic [c_W-1:0] b,
                            input bit stopAtDone, input int holdFrom, input int holdTo,
                            output int doneCycle, output int doneCount, output int busyBad,
                            output logic [2*c_W-1:0] prod, output logic [2*c_W-1:0] prodCycle1);
        doneCycle  = -1;
        doneCount  = 0;
        busyBad    = 0;
        prod       = '0;
        prodCycle1 = '0;
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        @(posedge clock); #1;
        start        = 1'b0;
        multiplicand = 32'hA5A5_5A5A;
        multiplier   = 32'h5A5A_A5A5;
        for (int cyc = 1; cyc <= c_MAXCYC; cyc++) begin
            if (cyc == 1) prodCycle1 = product;
            if (busy !== ((cyc <= c_W) ? 1'b1 : 1'b0)) busyBad++;
            if (busy === 1'b1 && done === 1'b1) busyBad++;
            if (done === 1'b1) begin
                doneCount++;
                if (doneCycle < 0) begin
                    doneCycle = cyc;
                    prod      = product;
                end
            end
            if (stopAtDone && doneCycle > 0) break;
            start = (cyc >= holdFrom && cyc <= holdTo);
            if (start) begin
                multiplicand = ~a;
                multiplier   = ~b;
            end
            @(posedge clock); #1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (product !== 64'h0) begin errors++; $display("FAIL reset_product: got %h want 0", product); end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int dc, dn, bb;
        logic [2*c_W-1:0] p, p1;
        run_mult(32'd3, 32'd5, 1'b0, 0, -1, dc, dn, bb, p, p1);
        checks++; if (dc !== c_LATENCY) begin errors++; $display("FAIL basic_latency: got %0d want %0d", dc, c_LATENCY); end
        checks++; if (dn !== 1) begin errors++; $display("FAIL basic_done_pulses: got %0d want 1", dn); end
        checks++; if (p !== 64'h0000_0000_0000_000F) begin errors++; $display("FAIL basic_product: got %h want 000000000000000f", p); end
        checks++; if (bb !== 0) begin errors++; $display("FAIL basic_busy_window: got %0d bad cycles want 0", bb); end
    endtask

    task automatic test_max();
        int dc, dn, bb;
        logic [2*c_W-1:0] p, p1;
        run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, -1, dc, dn, bb, p, p1);
        checks++; if (p !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL max_product: got %h want fffffffe00000001", p); end
        checks++; if (dc !== c_LATENCY) begin errors++; $display("FAIL max_latency: got %0d want %0d", dc, c_LATENCY); end
    endtask

    task automatic test_zero_identity();
        int dc, dn, bb;
        logic [2*c_W-1:0] p, p1;
        run_mult(32'h0, 32'hDEAD_BEEF, 1'b0, 0, -1, dc, dn, bb, p, p1);
        checks++; if (p !== 64'h0) begin errors++; $display("FAIL zero_product: got %h want 0", p); end
        checks++; if (dc !== c_LATENCY) begin errors++; $display("FAIL zero_latency: got %0d want %0d", dc, c_LATENCY); end
        run_mult(32'h1234_5678, 32'h1, 1'b0, 0, -1, dc, dn, bb, p, p1);
        checks++; if (p !== 64'h0000_0000_1234_5678) begin errors++; $display("FAIL ident_product: got %h want 0000000012345678", p); end
        checks++; if (dc !== c_LATENCY) begin errors++; $display("FAIL ident_latency: got %0d want %0d", dc, c_LATENCY); end
    endtask

    task automatic test_start_in_busy();
        int dc, dn, bb;
        logic [2*c_W-1:0] p, p1;
        run_mult(32'd3, 32'd5, 1'b0, 5, 10, dc, dn, bb, p, p1);
        checks++; if (p !== 64'hF) begin errors++; $display("FAIL busy_start_product: got %h want 000000000000000f", p); end
        checks++; if (dn !== 1) begin errors++; $display("FAIL busy_start_pulses: got %0d want 1", dn); end
        checks++; if (dc !== c_LATENCY) begin errors++; $display("FAIL busy_start_latency: got %0d want %0d", dc, c_LATENCY); end
        checks++; if (bb !== 0) begin errors++; $display("FAIL busy_start_window: got %0d bad cycles want 0", bb); end
    endtask

    task automatic test_reset_mid();
        int dc, dn, bb;
        int sawDone;
        logic [2*c_W-1:0] p, p1;
        // 9 * 11: every multiplier bit lies in the low 16, so the
        // accumulator already holds 99 after 16 iterations
        multiplicand = 32'd9;
        multiplier   = 32'd11;
        start        = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (16) begin
            @(posedge clock); #1;
        end
        checks++; if (product !== 64'd99) begin errors++; $display("FAIL mid_partial: got %h want 63", product); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_reset_done: got %b want 0", done); end
        checks++; if (product !== 64'h0) begin errors++; $display("FAIL mid_reset_product: got %h want 0", product); end
        sawDone = 0;
        repeat (3) begin
            @(posedge clock); #1;
            if (done !== 1'b0) sawDone++;
        end
        reset = 1'b0;
        checks++; if (sawDone !== 0) begin errors++; $display("FAIL mid_reset_no_done: got %0d pulses want 0", sawDone); end
        run_mult(32'd7, 32'd6, 1'b0, 0, -1, dc, dn, bb, p, p1);
        checks++; if (p !== 64'd42) begin errors++; $display("FAIL after_reset_product: got %h want 2a", p); end
        checks++; if (dc !== c_LATENCY) begin errors++; $display("FAIL after_reset_latency: got %0d want %0d", dc, c_LATENCY); end
    endtask

    task automatic test_back_to_back();
        int dc, dn, bb;
        logic [2*c_W-1:0] p, p1;
        run_mult(32'd3, 32'd5, 1'b1, 0, -1, dc, dn, bb, p, p1);
        checks++; if (dc !== c_LATENCY) begin errors++; $display("FAIL b2b_first_latency: got %0d want %0d", dc, c_LATENCY); end
        checks++; if (p !== 64'hF) begin errors++; $display("FAIL b2b_first_product: got %h want f", p); end
        // Second start is issued while still in the done cycle
        run_mult(32'd2, 32'h8000_0000, 1'b0, 0, -1, dc, dn, bb, p, p1);
        checks++; if (p1 !== 64'h0) begin errors++; $display("FAIL b2b_product_cleared: got %h want 0", p1); end
        checks++; if (dc !== c_LATENCY) begin errors++; $display("FAIL b2b_second_latency: got %0d want %0d", dc, c_LATENCY); end
        checks++; if (p !== 64'h0000_0001_0000_0000) begin errors++; $display("FAIL b2b_second_product: got %h want 0000000100000000", p); end
        checks++; if (bb !== 0) begin errors++; $display("FAIL b2b_busy_window: got %0d bad cycles want 0", bb); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_zero_identity();
        test_start_in_busy();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_seq_shift_add_multiplier
`default_nettype wire
